// File: rtl/kbd_cmd_pkg.sv
// Shared types, ASCII constants and the command-to-key mapping for the keyboard command encoder.
package kbd_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_D = 3'd0,
        CMD_E = 3'd1,
        CMD_B = 3'd2,
        CMD_F = 3'd3,
        CMD_R = 3'd4
    } cmd_code_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_D_UPPER = 8'h44;
    localparam logic [7:0] ASCII_E_UPPER = 8'h45;
    localparam logic [7:0] ASCII_B_UPPER = 8'h42;
    localparam logic [7:0] ASCII_F_UPPER = 8'h46;
    localparam logic [7:0] ASCII_R_UPPER = 8'h52;
    localparam logic [7:0] ASCII_D_LOWER = 8'h64;
    localparam logic [7:0] ASCII_E_LOWER = 8'h65;
    localparam logic [7:0] ASCII_B_LOWER = 8'h62;
    localparam logic [7:0] ASCII_F_LOWER = 8'h66;
    localparam logic [7:0] ASCII_R_LOWER = 8'h72;

    // Codes above CMD_R have no key assigned and are dropped at the input.
    function automatic logic cmd_is_valid(input logic [2:0] code);
        return (code <= 3'(CMD_R));
    endfunction

    // Translate a queued command into the key byte placed on kbd.
    function automatic logic [7:0] cmd_to_ascii(input logic [2:0] code, input logic upper);
        logic [7:0] ch;
        ch = 8'h00;
        case (code)
            CMD_D:   ch = upper ? ASCII_D_UPPER : ASCII_D_LOWER;
            CMD_E:   ch = upper ? ASCII_E_UPPER : ASCII_E_LOWER;
            CMD_B:   ch = upper ? ASCII_B_UPPER : ASCII_B_LOWER;
            CMD_F:   ch = upper ? ASCII_F_UPPER : ASCII_F_LOWER;
            CMD_R:   ch = upper ? ASCII_R_UPPER : ASCII_R_LOWER;
            default: ch = 8'h00;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO holding accepted command codes until the key FSM is ready for them.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    import kbd_cmd_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full queue is only honoured when a pop frees a slot on the same edge.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/kbd_cmd_encoder.sv
// Turns queued single-letter commands into timed key presses: each key is held, then released for a gap.
module kbd_cmd_encoder #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter bit UPPER       = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_code,
    output logic       cmd_ready,
    output logic [7:0] kbd,
    output logic       kbd_valid,
    output logic       busy,
    output logic       err_invalid
);
    import kbd_cmd_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

    state_t          state;
    state_t          state_next;
    logic [7:0]      cnt;
    logic [7:0]      cnt_next;
    logic [7:0]      kbd_next;
    logic            kbd_valid_next;
    logic            handshake;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [2:0]      head_code;

    assign handshake = cmd_valid && cmd_ready;
    assign fifo_push = handshake && cmd_is_valid(cmd_code);
    assign cmd_ready = !fifo_full;
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (cmd_code),
        .pop       (fifo_pop),
        .pop_data  (head_code),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next-state logic: pop and present a key from IDLE, count out the hold, then count out the gap.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        kbd_next       = kbd;
        kbd_valid_next = kbd_valid;
        fifo_pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop       = 1'b1;
                    kbd_next       = cmd_to_ascii(head_code, UPPER);
                    kbd_valid_next = 1'b1;
                    cnt_next       = 8'd0;
                    state_next     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    kbd_next       = 8'h00;
                    kbd_valid_next = 1'b0;
                    cnt_next       = 8'd0;
                    state_next     = ST_GAP;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_next   = 8'd0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            default: begin
                kbd_next       = 8'h00;
                kbd_valid_next = 1'b0;
                cnt_next       = 8'd0;
                state_next     = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; err_invalid pulses for the cycle after a dropped code.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= 8'd0;
            kbd         <= 8'h00;
            kbd_valid   <= 1'b0;
            err_invalid <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            kbd         <= kbd_next;
            kbd_valid   <= kbd_valid_next;
            err_invalid <= handshake && !cmd_is_valid(cmd_code);
        end
    end

endmodule

// File: tb/tb_kbd_cmd_encoder.sv
// Self-checking bench: two encoders (upper/lower case) driven together against a timeline model.
module tb_kbd_cmd_encoder;

    localparam int HOLD  = 4;
    localparam int GAP   = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic [2:0] cmd_code;

    logic       ready_uc, valid_uc, busy_uc, err_uc;
    logic [7:0] kbd_uc;
    logic       ready_lc, valid_lc, busy_lc, err_lc;
    logic [7:0] kbd_lc;

    int errors = 0;
    int checks = 0;
    int t      = 0;

    // Reference model: list of queued codes plus the edge on which the current key started.
    int         q[$];
    bit         active   = 1'b0;
    int         s        = 0;
    int         cur      = 0;
    bit         exp_err  = 1'b0;
    int         accepted = 0;
    logic [7:0] upper_map [5] = '{8'h44, 8'h45, 8'h42, 8'h46, 8'h52};

    always #5 clk = ~clk;

    kbd_cmd_encoder #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH), .UPPER(1'b1)) dut_uc (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_ready(ready_uc), .kbd(kbd_uc), .kbd_valid(valid_uc), .busy(busy_uc), .err_invalid(err_uc)
    );

    kbd_cmd_encoder #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH), .UPPER(1'b0)) dut_lc (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_ready(ready_lc), .kbd(kbd_lc), .kbd_valid(valid_lc), .busy(busy_lc), .err_invalid(err_lc)
    );

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s at edge %0d: observed %02h expected %02h", tag, t, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs the bench applied before it.
    task automatic modelEdge();
        bit ready_pre;
        if (!reset_n) begin
            q.delete();
            active  = 1'b0;
            exp_err = 1'b0;
        end else begin
            ready_pre = (q.size() < DEPTH);
            if ((!active || (t - s) > (HOLD + GAP)) && q.size() > 0) begin
                s      = t;
                active = 1'b1;
                cur    = q.pop_front();
            end
            exp_err = 1'b0;
            if (cmd_valid && ready_pre) begin
                accepted++;
                if (cmd_code < 3'd5) q.push_back(int'(cmd_code));
                else exp_err = 1'b1;
            end
        end
    endtask

    task automatic checkAll();
        bit         e_valid;
        bit         e_busy;
        bit         e_ready;
        logic [7:0] e_kbd;
        e_valid = active && ((t - s) < HOLD);
        e_busy  = (q.size() != 0) || (active && ((t - s) < (HOLD + GAP)));
        e_ready = (q.size() < DEPTH);
        e_kbd   = e_valid ? upper_map[cur] : 8'h00;
        checkOutput("kbd_uc",   kbd_uc,   e_kbd);
        checkOutput("valid_uc", valid_uc, e_valid);
        checkOutput("busy_uc",  busy_uc,  e_busy);
        checkOutput("ready_uc", ready_uc, e_ready);
        checkOutput("err_uc",   err_uc,   exp_err);
        checkOutput("kbd_lc",   kbd_lc,   e_valid ? (e_kbd | 8'h20) : 8'h00);
        checkOutput("valid_lc", valid_lc, e_valid);
        checkOutput("busy_lc",  busy_lc,  e_busy);
        checkOutput("ready_lc", ready_lc, e_ready);
        checkOutput("err_lc",   err_lc,   exp_err);
    endtask

    task automatic applyStimulus(input bit v, input int code, input bit rn);
        @(negedge clk);
        checkAll();
        cmd_valid = v;
        cmd_code  = 3'(code);
        reset_n   = rn;
        @(posedge clk);
        t++;
        modelEdge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b1);
    endtask

    initial begin
        int burst_codes [6];
        int n0;
        int guard;
        burst_codes = '{3, 0, 4, 1, 2, 0};

        reset_n   = 1'b0;
        cmd_valid = 1'b1;
        cmd_code  = 3'd0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            t++;
            modelEdge();
        end

        $display("[TB] reset state");
        idle(2);

        $display("[TB] single key from idle");
        applyStimulus(1'b1, 0, 1'b1);
        idle(12);

        $display("[TB] three keys back to back");
        applyStimulus(1'b1, 4, 1'b1);
        applyStimulus(1'b1, 1, 1'b1);
        applyStimulus(1'b1, 2, 1'b1);
        idle(25);

        $display("[TB] burst of six with valid held");
        n0    = accepted;
        guard = 0;
        while ((accepted - n0) < 6 && guard < 200) begin
            applyStimulus(1'b1, burst_codes[accepted - n0], 1'b1);
            guard++;
        end
        checkOutput("burst_accept_timeout", 8'(guard < 200), 8'd1);
        idle(50);

        $display("[TB] invalid code");
        applyStimulus(1'b1, 7, 1'b1);
        idle(5);
        applyStimulus(1'b1, 5, 1'b1);
        idle(3);

        $display("[TB] reset in the middle of a held key");
        applyStimulus(1'b1, 1, 1'b1);
        applyStimulus(1'b1, 3, 1'b1);
        applyStimulus(1'b1, 0, 1'b1);
        idle(2);
        applyStimulus(1'b1, 2, 1'b0);
        idle(30);

        $display("[TB] full queue with valid held through pops");
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, int'($urandom_range(0, 4)), 1'b1);
        idle(40);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 2) != 0, int'($urandom_range(0, 7)),
                          $urandom_range(0, 199) != 0);
        end
        idle(40);
        @(negedge clk);
        checkAll();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
